// File: rtl/uart_tx.sv
// uart_tx: serial transmitter with configurable bit period, optional parity and 1 or 2 stop bits
module uart_tx #(
  parameter int DATA_W = 8,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              start,
  input  logic [12:0]       bit_period,
  input  logic              parity_en,
  input  logic              parity_odd,
  output logic              tx,
  output logic              busy,
  output logic              done
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [12:0] timer, per;
  logic [2:0] idx;
  logic [DATA_W-1:0] data;
  logic par_en, par_odd, last, accept;
  always_comb begin
    accept = state == IDLE && start;
    last = timer == per - 13'd1;
    state_n = state;
    case (state)
      IDLE:    state_n = start ? START : IDLE;
      START:   state_n = last ? DATA : START;
      DATA:    state_n = (last && idx == 3'(DATA_W - 1)) ? (par_en ? PARITY : STOP) : DATA;
      PARITY:  state_n = last ? STOP : PARITY;
      STOP:    state_n = (last && idx == 3'(STOP_BITS - 1)) ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
    tx = state == START  ? 1'b0 :
         state == DATA   ? data[idx] :
         state == PARITY ? ^data ^ par_odd : 1'b1;
    busy = state != IDLE;
    done = state == STOP && last && idx == 3'(STOP_BITS - 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      idx <= '0;
      data <= '0;
      per <= '0;
      par_en <= 1'b0;
      par_odd <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        data <= data_in;
        per <= bit_period == 13'd0 ? 13'd1 : bit_period;
        par_en <= parity_en;
        par_odd <= parity_odd;
        timer <= '0;
        idx <= '0;
      end else if (state != IDLE) begin
        // idx counts data bits in DATA and stop bits in STOP; restart on every state change
        timer <= last ? 13'd0 : timer + 13'd1;
        if (last) idx <= state_n != state ? 3'd0 : idx + 3'd1;
      end
    end
  end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving data bits per frame (5..8).
REQ-002 The block SHALL have parameter STOP_BITS, default 1, giving stop bits per frame (1 or 2).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all logic on rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port data_in, input, DATA_W bits: byte to transmit, sampled on accept.
REQ-006 The block SHALL have port start, input, 1 bit: request to send data_in.
REQ-007 The block SHALL have port bit_period, input, 13 bits: clk cycles per serial bit, sampled on accept.
REQ-008 The block SHALL have port parity_en, input, 1 bit: insert a parity bit, sampled on accept.
REQ-009 The block SHALL have port parity_odd, input, 1 bit: 1 = odd parity, 0 = even, sampled on accept.
REQ-010 The block SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-011 The block SHALL have port busy, output, 1 bit: frame in progress.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle end-of-frame pulse.

Function
REQ-013 The block SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-014 In IDLE, start=1 SHALL be accepted: data_in, bit_period, parity_en, parity_odd latched; next state START.
REQ-015 start SHALL be ignored while busy=1; no queuing, latched values unchanged.
REQ-016 busy SHALL be 1 in every state except IDLE, rising the cycle after accept.
REQ-017 tx SHALL be 0 in START, the current data bit in DATA, the parity bit in PARITY, and 1 in STOP and IDLE.
REQ-018 tx SHALL go low the first cycle after accept (latency 1 cycle).
REQ-019 Each bit SHALL last exactly bit_period cycles; a latched bit_period of 0 SHALL be treated as 1.
REQ-020 The bit timer SHALL be a 13-bit counter reset at each bit boundary; no drift across bits.
REQ-021 Data SHALL be sent LSB first, DATA_W bits, tracked by a bit index counter.
REQ-022 DATA SHALL transition to PARITY if latched parity_en=1, else to STOP.
REQ-023 The parity bit SHALL be the XOR of the latched data bits, inverted when parity_odd=1.
REQ-024 STOP SHALL last STOP_BITS x bit_period cycles.
REQ-025 done SHALL be 1 only during the final cycle of STOP; the next state SHALL be IDLE with busy=0.
REQ-026 start asserted during the done cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted, so frames are separated by at least one idle-high cycle.
REQ-027 Frame length SHALL be (1 + DATA_W + parity_en + STOP_BITS) x max(bit_period,1) cycles from the first tx-low cycle through the done cycle.
REQ-028 Changes on data_in, bit_period or the parity inputs during a frame SHALL NOT affect that frame.

Reset
REQ-029 rst=1 SHALL force state IDLE, tx=1, busy=0, done=0, and clear the timer, bit index and latched registers.
REQ-030 rst SHALL take priority over start and abort any frame in progress; tx SHALL be 1 the cycle after rst.
REQ-031 After rst deasserts, start SHALL be accepted on the first cycle.

Verification
REQ-032 Bench SHALL check: data_in=0xA5, bit_period=4, no parity -> tx low 4 cycles, then 1,0,1,0,0,1,0,1 each 4 cycles, then high 4 cycles, done on cycle 40 after tx falls.
REQ-033 Bench SHALL check: 0xA5, parity_en=1 -> parity bit 0 when parity_odd=0 and 1 when parity_odd=1; done on cycle 44.
REQ-034 Bench SHALL check: bit_period=0 and bit_period=1 -> identical 1-cycle bits, 10-cycle frame.
REQ-035 Bench SHALL check: start held high continuously with data_in changing mid-frame -> each frame carries its accept-time byte, one idle-high cycle between frames, done once per frame.
REQ-036 Bench SHALL check: rst asserted mid-DATA -> tx=1, busy=0, done never pulses; a new start after reset yields a complete correct frame.
REQ-037 Bench SHALL check: STOP_BITS=2, bit_period=3 -> stop high 6 cycles, done in last stop cycle.
